// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the memory responder: grant encoding,
// SRAM region decode and the default read value for unmapped addresses.
package mem_pkg;

    // What was granted in a cycle; registered to steer next-cycle rdy/data.
    typedef enum logic [2:0] {
        NONE         = 3'd0,
        INS          = 3'd1,
        DRD          = 3'd2,
        DRD_UNMAPPED = 3'd3,
        DWR          = 3'd4
    } grant_t;

    localparam logic [15:0] UNMAPPED_DEFAULT = 16'hEEEE;
    localparam logic [3:0]  SRAM_SEL_DEFAULT = 4'h0;

    // True when the top nibble of a 16-bit address selects the SRAM bank.
    function automatic logic in_sram(input logic [15:0] addr, input logic [3:0] sel);
        return (addr >> 12) == 16'(sel);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Bundle of the cpu16 instruction/data ports, the debug write stream and
// the SRAM macro pins as seen by the memory responder.
interface mem_responder_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int MEM_AW = 8
);
    logic [ADDR_W-1:0] ins_rd_addr;
    logic              ins_rd_req;
    logic              ins_rd_rdy;
    logic [DATA_W-1:0] ins_rd_data;

    logic [ADDR_W-1:0] dat_rw_addr;
    logic [DATA_W-1:0] dat_wr_data;
    logic              dat_rd_req;
    logic              dat_wr_req;
    logic              dat_rd_rdy;
    logic              dat_wr_rdy;
    logic [DATA_W-1:0] dat_rd_data;

    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_waddr;
    logic [DATA_W-1:0] dbg_wdata;

    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    // Responder side.
    modport slave (
        input  ins_rd_addr, ins_rd_req, dat_rw_addr, dat_wr_data, dat_rd_req,
               dat_wr_req, dbg_we, dbg_waddr, dbg_wdata, mem_rdata,
        output ins_rd_rdy, ins_rd_data, dat_rd_rdy, dat_wr_rdy, dat_rd_data,
               mem_addr, mem_wdata, mem_we, mem_re
    );

    // CPU / debug / SRAM side.
    modport master (
        output ins_rd_addr, ins_rd_req, dat_rw_addr, dat_wr_data, dat_rd_req,
               dat_wr_req, dbg_we, dbg_waddr, dbg_wdata, mem_rdata,
        input  ins_rd_rdy, ins_rd_data, dat_rd_rdy, dat_wr_rdy, dat_rd_data,
               mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/mem_responder_arb_pick.sv
// Combinational priority selector for the single SRAM port.
// Order: debug write, promoted instruction fetch, data write, data read,
// instruction fetch. Debug writes take the port but produce no grant.
module mem_arb_pick
    import mem_pkg::*;
(
    input  logic   i_ins_req,
    input  logic   i_drd_req,
    input  logic   i_dwr_req,
    input  logic   i_dbg_we,
    input  logic   i_starve,
    input  logic   i_dat_sram,
    input  logic   i_dbg_sram,
    output grant_t o_grant,
    output logic   o_mem_re,
    output logic   o_mem_we,
    output logic   o_dbg_sel
);

    // Pick at most one owner of the SRAM port this cycle.
    always_comb begin
        o_grant   = NONE;
        o_mem_re  = 1'b0;
        o_mem_we  = 1'b0;
        o_dbg_sel = 1'b0;
        if (i_dbg_we) begin
            o_dbg_sel = 1'b1;
            o_mem_we  = i_dbg_sram;
        end else if (i_ins_req && i_starve) begin
            o_grant  = INS;
            o_mem_re = 1'b1;
        end else if (i_dwr_req) begin
            o_grant  = DWR;
            o_mem_we = i_dat_sram;
        end else if (i_drd_req) begin
            if (i_dat_sram) begin
                o_grant  = DRD;
                o_mem_re = 1'b1;
            end else begin
                o_grant = DRD_UNMAPPED;
            end
        end else if (i_ins_req) begin
            o_grant  = INS;
            o_mem_re = 1'b1;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: arbitrates cpu16 instruction/data ports and the
// unstallable debug write stream onto one single-port SRAM bank, and
// returns rdy plus read data one cycle after each grant.
module mem_responder
    import mem_pkg::*;
#(
    parameter int                ADDR_W     = 16,
    parameter int                DATA_W     = 16,
    parameter int                MEM_AW     = 8,
    parameter logic [3:0]        SRAM_SEL   = SRAM_SEL_DEFAULT,
    parameter logic [DATA_W-1:0] UNMAPPED   = UNMAPPED_DEFAULT,
    parameter int                STARVE_MAX = 3
)(
    input  logic           clk,
    input  logic           reset_n,
    mem_responder_if.slave bus
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    grant_t             w_grant;
    logic               w_mem_re;
    logic               w_mem_we;
    logic               w_dbg_sel;
    logic               w_dat_sram;
    logic               w_dbg_sram;
    logic               w_starve;
    logic               w_dat_owner;

    grant_t             r_grant;
    logic [CNT_W-1:0]   r_starve;
    logic [DATA_W-1:0]  r_ins_data;
    logic [DATA_W-1:0]  r_dat_data;

    // Address bits between the SRAM word index and the region nibble carry
    // no meaning here; instruction fetches ignore the region entirely.
    logic w_unused_addr_bits;
    assign w_unused_addr_bits = ^{bus.ins_rd_addr[ADDR_W-1:MEM_AW],
                                  bus.dat_rw_addr[ADDR_W-5:MEM_AW],
                                  bus.dbg_waddr[ADDR_W-5:MEM_AW]};

    assign w_dat_sram = in_sram(bus.dat_rw_addr, SRAM_SEL);
    assign w_dbg_sram = in_sram(bus.dbg_waddr, SRAM_SEL);
    assign w_starve   = (r_starve == CNT_W'(STARVE_MAX));

    mem_arb_pick u_pick (
        .i_ins_req  (bus.ins_rd_req),
        .i_drd_req  (bus.dat_rd_req),
        .i_dwr_req  (bus.dat_wr_req),
        .i_dbg_we   (bus.dbg_we),
        .i_starve   (w_starve),
        .i_dat_sram (w_dat_sram),
        .i_dbg_sram (w_dbg_sram),
        .o_grant    (w_grant),
        .o_mem_re   (w_mem_re),
        .o_mem_we   (w_mem_we),
        .o_dbg_sel  (w_dbg_sel)
    );

    // The data port owns the SRAM pins for any data grant; otherwise the
    // instruction port is the default source when nothing is enabled.
    assign w_dat_owner = (w_grant == DWR) || (w_grant == DRD) || (w_grant == DRD_UNMAPPED);

    assign bus.mem_re    = w_mem_re;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = w_dbg_sel   ? bus.dbg_waddr[MEM_AW-1:0]   :
                           w_dat_owner ? bus.dat_rw_addr[MEM_AW-1:0] :
                                         bus.ins_rd_addr[MEM_AW-1:0];
    assign bus.mem_wdata = w_dbg_sel ? bus.dbg_wdata : bus.dat_wr_data;

    // Record this cycle's grant so the following cycle raises the right rdy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_grant <= NONE;
        end else begin
            r_grant <= w_grant;
        end
    end

    // Count consecutive denied fetch cycles; saturate to promote the fetch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve <= '0;
        end else if (bus.ins_rd_req && (w_grant != INS)) begin
            if (!w_starve) begin
                r_starve <= r_starve + CNT_W'(1);
            end
        end else begin
            r_starve <= '0;
        end
    end

    // Capture returned read data so it stays visible after the rdy cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ins_data <= '0;
            r_dat_data <= '0;
        end else begin
            if (r_grant == INS) begin
                r_ins_data <= bus.mem_rdata;
            end
            if (r_grant == DRD) begin
                r_dat_data <= bus.mem_rdata;
            end else if (r_grant == DRD_UNMAPPED) begin
                r_dat_data <= UNMAPPED;
            end
        end
    end

    assign bus.ins_rd_rdy  = (r_grant == INS);
    assign bus.dat_wr_rdy  = (r_grant == DWR);
    assign bus.dat_rd_rdy  = (r_grant == DRD) || (r_grant == DRD_UNMAPPED);

    assign bus.ins_rd_data = (r_grant == INS)          ? bus.mem_rdata : r_ins_data;
    assign bus.dat_rd_data = (r_grant == DRD)          ? bus.mem_rdata :
                             (r_grant == DRD_UNMAPPED) ? UNMAPPED      : r_dat_data;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: SRAM behavioural model, scoreboard queues filled
// when requests are driven and drained when rdy pulses appear.
module tb_mem_responder;

    logic clk;
    logic reset_n;

    mem_responder_if bus_if ();

    mem_responder u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] sram   [0:255];
    logic [15:0] shadow [0:255];

    logic [15:0] exp_ins [$];
    logic [15:0] exp_drd [$];
    int          exp_dwr [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // SRAM macro model: write on we, registered read data after re.
    always @(posedge clk) begin
        if (bus_if.mem_we) sram[bus_if.mem_addr] <= bus_if.mem_wdata;
        if (bus_if.mem_re) bus_if.mem_rdata <= sram[bus_if.mem_addr];
    end

    // Scoreboard drain on rdy pulses.
    always @(negedge clk) begin
        if (bus_if.ins_rd_rdy) begin
            if (exp_ins.size() == 0) check_eq("ins_spurious_rdy", 1, 0);
            else check_eq("ins_data", {16'h0, bus_if.ins_rd_data}, {16'h0, exp_ins.pop_front()});
        end
        if (bus_if.dat_rd_rdy) begin
            if (exp_drd.size() == 0) check_eq("drd_spurious_rdy", 1, 0);
            else check_eq("drd_data", {16'h0, bus_if.dat_rd_data}, {16'h0, exp_drd.pop_front()});
        end
        if (bus_if.dat_wr_rdy) begin
            check_eq("dwr_expected", (exp_dwr.size() != 0) ? 1 : 0, 1);
            if (exp_dwr.size() != 0) void'(exp_dwr.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            sram[i]   = 16'h0;
            shadow[i] = 16'h0;
        end
        bus_if.mem_rdata   = 16'h0;
        bus_if.ins_rd_addr = 16'h0;
        bus_if.ins_rd_req  = 1'b0;
        bus_if.dat_rw_addr = 16'h0;
        bus_if.dat_wr_data = 16'h0;
        bus_if.dat_rd_req  = 1'b0;
        bus_if.dat_wr_req  = 1'b0;
        bus_if.dbg_we      = 1'b0;
        bus_if.dbg_waddr   = 16'h0;
        bus_if.dbg_wdata   = 16'h0;
        reset_n            = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_ins_rdy",  bus_if.ins_rd_rdy, 0);
        check_eq("rst_drd_rdy",  bus_if.dat_rd_rdy, 0);
        check_eq("rst_dwr_rdy",  bus_if.dat_wr_rdy, 0);
        check_eq("rst_ins_data", bus_if.ins_rd_data, 0);
        check_eq("rst_drd_data", bus_if.dat_rd_data, 0);
        tick();
        reset_n = 1'b1;

        // Preload SRAM[5] through the debug port, then a non-SRAM debug write
        bus_if.dbg_we = 1'b1; bus_if.dbg_waddr = 16'h0005; bus_if.dbg_wdata = 16'h1234;
        @(negedge clk);
        check_eq("dbg_we",    bus_if.mem_we, 1);
        check_eq("dbg_addr",  bus_if.mem_addr, 8'h05);
        check_eq("dbg_wdata", bus_if.mem_wdata, 16'h1234);
        shadow[5] = 16'h1234;
        tick();
        bus_if.dbg_waddr = 16'h9005; bus_if.dbg_wdata = 16'hDEAD;
        @(negedge clk);
        check_eq("dbg_unmapped_we", bus_if.mem_we, 0);
        tick();
        bus_if.dbg_we = 1'b0;

        // Single instruction fetch
        bus_if.ins_rd_req = 1'b1; bus_if.ins_rd_addr = 16'h0005;
        @(negedge clk);
        check_eq("fetch_re", bus_if.mem_re, 1);
        check_eq("fetch_rdy_early", bus_if.ins_rd_rdy, 0);
        exp_ins.push_back(shadow[5]);
        tick();
        bus_if.ins_rd_req = 1'b0;
        @(negedge clk);
        check_eq("fetch_rdy", bus_if.ins_rd_rdy, 1);
        tick();
        @(negedge clk);
        check_eq("fetch_rdy_drop", bus_if.ins_rd_rdy, 0);
        check_eq("fetch_data_hold", bus_if.ins_rd_data, 16'h1234);
        tick();

        // Data write and fetch to the same address: write wins
        bus_if.dat_wr_req = 1'b1; bus_if.dat_rw_addr = 16'h0010; bus_if.dat_wr_data = 16'hBEEF;
        bus_if.ins_rd_req = 1'b1; bus_if.ins_rd_addr = 16'h0010;
        @(negedge clk);
        check_eq("wr_first_we", bus_if.mem_we, 1);
        check_eq("wr_first_re", bus_if.mem_re, 0);
        shadow[8'h10] = 16'hBEEF;
        exp_dwr.push_back(16'h0010);
        exp_ins.push_back(shadow[8'h10]);
        tick();
        bus_if.dat_wr_req = 1'b0;
        @(negedge clk);
        check_eq("wr_rdy", bus_if.dat_wr_rdy, 1);
        check_eq("ins_wait_rdy", bus_if.ins_rd_rdy, 0);
        check_eq("ins_after_wr_re", bus_if.mem_re, 1);
        tick();
        bus_if.ins_rd_req = 1'b0;
        @(negedge clk);
        check_eq("ins_after_wr_rdy", bus_if.ins_rd_rdy, 1);
        tick();

        // Unmapped data read, then mapped data read, then unmapped data write
        bus_if.dat_rd_req = 1'b1; bus_if.dat_rw_addr = 16'h8003;
        @(negedge clk);
        check_eq("unmapped_rd_re", bus_if.mem_re, 0);
        exp_drd.push_back(16'hEEEE);
        tick();
        bus_if.dat_rw_addr = 16'h0005;
        @(negedge clk);
        check_eq("unmapped_rd_rdy", bus_if.dat_rd_rdy, 1);
        check_eq("mapped_rd_re", bus_if.mem_re, 1);
        exp_drd.push_back(shadow[5]);
        tick();
        bus_if.dat_rd_req = 1'b0;
        bus_if.dat_wr_req = 1'b1; bus_if.dat_rw_addr = 16'h8010; bus_if.dat_wr_data = 16'h5555;
        @(negedge clk);
        check_eq("mapped_rd_rdy", bus_if.dat_rd_rdy, 1);
        check_eq("unmapped_wr_we", bus_if.mem_we, 0);
        exp_dwr.push_back(16'h8010);
        tick();
        bus_if.dat_wr_req = 1'b0;
        @(negedge clk);
        check_eq("unmapped_wr_rdy", bus_if.dat_wr_rdy, 1);
        check_eq("drd_data_hold", bus_if.dat_rd_data, 16'h1234);
        tick();

        // Debug stream starves a held fetch for six cycles
        bus_if.ins_rd_req = 1'b1; bus_if.ins_rd_addr = 16'h0005;
        bus_if.dbg_we = 1'b1; bus_if.dbg_waddr = 16'h0020;
        for (int i = 0; i < 6; i++) begin
            bus_if.dbg_wdata = 16'hA000 + 16'(i);
            @(negedge clk);
            check_eq("dbg_hold_we", bus_if.mem_we, 1);
            check_eq("dbg_hold_addr", bus_if.mem_addr, 8'h20);
            check_eq("dbg_hold_re", bus_if.mem_re, 0);
            check_eq("dbg_hold_ins_rdy", bus_if.ins_rd_rdy, 0);
            shadow[8'h20] = 16'hA000 + 16'(i);
            tick();
        end
        bus_if.dbg_we = 1'b0;
        @(negedge clk);
        check_eq("dbg_release_re", bus_if.mem_re, 1);
        exp_ins.push_back(shadow[5]);
        tick();
        bus_if.ins_rd_req = 1'b0;
        @(negedge clk);
        check_eq("dbg_release_rdy", bus_if.ins_rd_rdy, 1);
        tick();

        // Continuous data traffic: fetch promoted on its 4th request cycle
        bus_if.dat_wr_req = 1'b1; bus_if.dat_rd_req = 1'b1;
        bus_if.dat_rw_addr = 16'h0030; bus_if.dat_wr_data = 16'h5A5A;
        bus_if.ins_rd_req = 1'b1; bus_if.ins_rd_addr = 16'h0020;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check_eq("starve_dwr_we", bus_if.mem_we, 1);
            check_eq("starve_dwr_re", bus_if.mem_re, 0);
            check_eq("starve_ins_rdy", bus_if.ins_rd_rdy, 0);
            shadow[8'h30] = 16'h5A5A;
            exp_dwr.push_back(16'h0030);
            tick();
        end
        @(negedge clk);
        check_eq("promote_re", bus_if.mem_re, 1);
        check_eq("promote_we", bus_if.mem_we, 0);
        check_eq("promote_addr", bus_if.mem_addr, 8'h20);
        exp_ins.push_back(shadow[8'h20]);
        tick();
        @(negedge clk);
        check_eq("post_promote_we", bus_if.mem_we, 1);
        check_eq("post_promote_rdy", bus_if.ins_rd_rdy, 1);
        exp_dwr.push_back(16'h0030);
        tick();
        bus_if.dat_wr_req = 1'b0; bus_if.dat_rd_req = 1'b0; bus_if.ins_rd_req = 1'b0;
        repeat (2) tick();

        // Reset in the cycle after a data read grant
        bus_if.dat_rd_req = 1'b1; bus_if.dat_rw_addr = 16'h0005;
        @(negedge clk);
        check_eq("abort_rd_re", bus_if.mem_re, 1);
        tick();
        bus_if.dat_rd_req = 1'b0;
        reset_n = 1'b0;
        #1;
        check_eq("abort_drd_rdy", bus_if.dat_rd_rdy, 0);
        @(negedge clk);
        check_eq("abort_drd_rdy_neg", bus_if.dat_rd_rdy, 0);
        check_eq("abort_ins_rdy", bus_if.ins_rd_rdy, 0);
        check_eq("abort_dwr_rdy", bus_if.dat_wr_rdy, 0);
        check_eq("abort_ins_data", bus_if.ins_rd_data, 0);
        check_eq("abort_drd_data", bus_if.dat_rd_data, 0);
        #2;
        reset_n = 1'b1;
        tick();
        bus_if.dat_rd_req = 1'b1; bus_if.dat_rw_addr = 16'h0010;
        @(negedge clk);
        check_eq("fresh_rd_re", bus_if.mem_re, 1);
        exp_drd.push_back(shadow[8'h10]);
        tick();
        bus_if.dat_rd_req = 1'b0;
        @(negedge clk);
        check_eq("fresh_rd_rdy", bus_if.dat_rd_rdy, 1);
        repeat (2) tick();

        check_eq("sb_ins_drained", exp_ins.size(), 0);
        check_eq("sb_drd_drained", exp_drd.size(), 0);
        check_eq("sb_dwr_drained", exp_dwr.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
